// File: rtl/alu_instr_issuer.sv
// Issues one ALU operation at a time as a packed instruction word and returns the ALU result on a response handshake.
// Legal ops respond ALU_LAT+1 cycles after accept, illegal ops after 1; only rsp_ready can stall the block.
package alu_pkg;
  typedef enum logic {UNSIGN = 1'b0, SIGN = 1'b1} op_type_t;

  typedef struct packed {
    logic [2:0]  opc;
    op_type_t    op_type;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } instr_t;

  typedef logic [63:0] l_data_t;

  localparam logic [2:0] OPC_DIV  = 3'd3;
  localparam logic [2:0] OPC_LAST = 3'd5;
endpackage

module alu_instr_issuer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_opc,
  input  logic             req_signed,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output instr_t           iw,
  output logic             iw_valid,
  input  l_data_t          alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt;
  logic [TAG_W-1:0] tag_cnt;
  logic             accept;
  logic             illegal;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  // The tag only advances on the response handshake, so the counter is the tag of the op in flight.
  assign rsp_tag   = tag_cnt;
  assign accept    = req_valid && req_ready;
  assign illegal   = (req_opc > OPC_LAST) || ((req_opc == OPC_DIV) && (req_b == 32'd0));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = illegal ? RESP : DRIVE;
      DRIVE:   if (cnt == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iw       <= '0;
      iw_valid <= 1'b0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      tag_cnt  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end else begin
              iw.opc     <= req_opc;
              iw.op_type <= req_signed ? SIGN : UNSIGN;
              iw.op_a    <= req_a;
              iw.op_b    <= req_b;
              iw_valid   <= 1'b1;
              cnt        <= CNT_INIT;
            end
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            rsp_data <= alu_res;
            rsp_err  <= 1'b0;
            iw_valid <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) tag_cnt <= tag_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
